// File: rtl/peripheral_spram_mport_pkg.sv
// peripheral_spram_pkg: shared types, limits and helpers for the multi-port RAM wrapper
package peripheral_spram_pkg;
  localparam int MAX_NCH = 8;
  localparam int MAX_BW = 64;
  typedef enum logic [1:0] {IDLE, CLEAR, READY} state_t;
  // never below 1 so the result can always size a vector
  function automatic int clog2(input int v);
    int r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic logic wen_is_read(input logic [MAX_BW-1:0] wen);
    return &wen;
  endfunction
endpackage

// File: rtl/peripheral_spram_mport_if.sv
// peripheral_spram_mport_if: per-channel request bundle plus the shared read-return path
interface peripheral_spram_mport_if #(
  parameter int NCH = 2,
  parameter int DW = 16,
  parameter int AW = 7
);
  localparam int BW = DW / 8;
  logic [NCH-1:0] req, gnt, rvalid;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] din;
  logic [NCH*BW-1:0] wen;
  logic [DW-1:0] dout;
  logic busy;
  modport master(output req, addr, din, wen, input gnt, rvalid, dout, busy);
  modport slave(input req, addr, din, wen, output gnt, rvalid, dout, busy);
endinterface

// File: rtl/peripheral_spram_mport_rr_arbiter.sv
// peripheral_spram_rr_arbiter: one-hot round-robin grant; search starts at the pointer
module peripheral_spram_rr_arbiter import peripheral_spram_pkg::*; #(
  parameter int NCH = 2,
  localparam int PW = clog2(NCH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NCH-1:0] req,
  input  logic busy,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0] win
);
  logic [PW-1:0] ptr, idx;
  logic found;
  always_comb begin
    win = ptr;
    idx = ptr;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = PW'((int'(ptr) + k) % NCH);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign gnt = (found && !busy) ? NCH'(1) << win : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (|gnt) ptr <= (32'(win) == NCH - 1) ? '0 : win + 1'b1;
endmodule

// File: rtl/peripheral_spram_mport.sv
// peripheral_spram_mport: NCH-channel round-robin front end on one inferred single-port RAM.
// Define PERIPHERAL_SPRAM_MPORT_INIT_CLEAR_EN to zero the whole array after every reset.
module peripheral_spram_mport import peripheral_spram_pkg::*; #(
  parameter int NCH = 2,
  parameter int DW = 16,
  parameter int MEM_SIZE = 256,
  parameter int AW = 7
) (
  input logic soc_ram_clk,
  input logic soc_ram_rst_n,
  peripheral_spram_mport_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int DEPTH = MEM_SIZE / BW;
  localparam int IW = clog2(DEPTH);
  localparam int PW = clog2(NCH);
  if (NCH < 1 || NCH > MAX_NCH || DW % 8 != 0) begin : g_bad_cfg
    $error("peripheral_spram_mport: unsupported NCH/DW");
  end
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] win;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;
  logic [BW-1:0] sel_wen;
  logic [IW-1:0] idx, cnt;
  logic acc, is_rd, in_range, clr_we, busy;
  // grants are held off during reset as well as while clearing
  peripheral_spram_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk(soc_ram_clk),
    .rst_n(soc_ram_rst_n),
    .req(bus.req),
    .busy(busy || !soc_ram_rst_n),
    .gnt(bus.gnt),
    .win(win)
  );
  assign bus.busy = busy;
  assign acc = |bus.gnt;
  assign sel_addr = bus.addr[win*AW +: AW];
  assign sel_din = bus.din[win*DW +: DW];
  assign sel_wen = bus.wen[win*BW +: BW];
  assign is_rd = wen_is_read({{(MAX_BW-BW){1'b1}}, sel_wen});
  assign in_range = 32'(sel_addr) < DEPTH;
  assign idx = sel_addr[IW-1:0];
  always_ff @(posedge soc_ram_clk)
    if (clr_we) mem[cnt] <= '0;
    else if (acc && !is_rd && in_range)
      for (int b = 0; b < BW; b++)
        if (!sel_wen[b]) mem[idx][b*8 +: 8] <= sel_din[b*8 +: 8];
  always_ff @(posedge soc_ram_clk or negedge soc_ram_rst_n)
    if (!soc_ram_rst_n) begin
      bus.rvalid <= '0;
      bus.dout <= '0;
    end else begin
      bus.rvalid <= (acc && is_rd) ? bus.gnt : '0;
      if (acc && is_rd) bus.dout <= in_range ? mem[idx] : '0;
    end
`ifdef PERIPHERAL_SPRAM_MPORT_INIT_CLEAR_EN
  state_t state, state_nxt;
  logic [IW-1:0] cnt_nxt;
  always_ff @(posedge soc_ram_clk or negedge soc_ram_rst_n)
    if (!soc_ram_rst_n) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    clr_we = state == CLEAR;
    busy = state != READY;
    if (state == IDLE) state_nxt = CLEAR;
    else if (state == CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      state_nxt = (32'(cnt) == DEPTH - 1) ? READY : CLEAR;
    end
  end
`else
  assign busy = 1'b0;
  assign clr_we = 1'b0;
  assign cnt = '0;
`endif
endmodule
